// File: rtl/ram_2port_sync.sv
// Simple dual-port RAM: one byte-enabled write port, one read port, optional zero-fill after reset.
// Read latency rd_latency (1 or 2) cycles from accepted re to r_valid; one read and one write per cycle.
// No backpressure on the ports; requests during zero-fill (init_busy) are dropped, not stalled.
module ram_2port_sync #(
  parameter int addr_width    = 3,
  parameter int data_width    = 8,
  parameter int rd_latency    = 1,
  parameter int rdw_mode      = 0,
  parameter int init_on_reset = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [addr_width-1:0]   w_addr,
  input  logic [data_width-1:0]   w_data,
  input  logic [data_width/8-1:0] w_be,
  input  logic                    re,
  input  logic [addr_width-1:0]   r_addr,
  output logic [data_width-1:0]   r_data,
  output logic                    r_valid,
  output logic                    init_busy
);

  localparam int depth = 2 ** addr_width;
  localparam int bytes = data_width / 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] INIT = 1'b1;

  localparam logic [addr_width-1:0] last_addr = {addr_width{1'b1}};

  // Illegal configurations stop elaboration.
  if (data_width % 8 != 0) begin : g_bad_width
    $error("ram_2port_sync: data_width must be a multiple of 8");
  end
  if (rd_latency != 1 && rd_latency != 2) begin : g_bad_latency
    $error("ram_2port_sync: rd_latency must be 1 or 2");
  end

  logic [data_width-1:0] mem [depth];
  logic [0:0]            state;
  logic [addr_width-1:0] fill_cnt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [data_width-1:0] rd_word;

  // Zero-fill sequencer: parked in INIT during reset, walks every address once after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (init_on_reset != 0) ? INIT : IDLE;
      fill_cnt <= '0;
    end else if (state == INIT) begin
      fill_cnt <= fill_cnt + 1'b1;
      if (fill_cnt == last_addr) begin
        state <= IDLE;
      end
    end
  end

  assign init_busy = (state == INIT);

  // Port requests only count once reset and the fill are both out of the way.
  assign wr_acc = we && !init_busy && !rst;
  assign rd_acc = re && !init_busy && !rst;

  // Read word: array contents, or write-first merge when the write hits the same address.
  always_comb begin
    rd_word = mem[r_addr];
    if (rdw_mode != 0 && wr_acc && (w_addr == r_addr)) begin
      for (int i = 0; i < bytes; i++) begin
        if (w_be[i]) begin
          rd_word[8*i +: 8] = w_data[8*i +: 8];
        end
      end
    end
  end

  // Array update: fill writes zero, otherwise byte-masked port write.
  always_ff @(posedge clk) begin
    if (!rst && init_busy) begin
      mem[fill_cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < bytes; i++) begin
        if (w_be[i]) begin
          mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
        end
      end
    end
  end

  if (rd_latency == 2) begin : g_lat2
    logic [data_width-1:0] s1_data;
    logic                  s1_vld;

    // Two-stage read path; r_data only moves when a valid word arrives.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_data <= '0;
        s1_vld  <= 1'b0;
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        s1_vld <= rd_acc;
        if (rd_acc) begin
          s1_data <= rd_word;
        end
        r_valid <= s1_vld;
        if (s1_vld) begin
          r_data <= s1_data;
        end
      end
    end
  end else begin : g_lat1
    // Single-stage read path; r_data holds between accepted reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= rd_acc;
        if (rd_acc) begin
          r_data <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_2port_sync.sv
// Bench for ram_2port_sync: two 16-bit instances share stimulus,
// A = latency 1 / old-data, B = latency 2 / write-first, both zero-filled after reset.
module tb_ram_2port_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  w_addr = '0;
  logic [15:0] w_data = '0;
  logic [1:0]  w_be = '0;
  logic        re = 1'b0;
  logic [2:0]  r_addr = '0;

  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid, a_busy, b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_2port_sync #(.addr_width(3), .data_width(16), .rd_latency(1), .rdw_mode(0), .init_on_reset(1)) dut_a (
    .clk(clk), .rst(rst), .we(we), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .re(re), .r_addr(r_addr), .r_data(a_data), .r_valid(a_valid), .init_busy(a_busy)
  );

  ram_2port_sync #(.addr_width(3), .data_width(16), .rd_latency(2), .rdw_mode(1), .init_on_reset(1)) dut_b (
    .clk(clk), .rst(rst), .we(we), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .re(re), .r_addr(r_addr), .r_data(b_data), .r_valid(b_valid), .init_busy(b_busy)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [15:0] m_mem [8];
  logic        m_busy = 1'b1;
  int          m_fill = 0;
  logic [15:0] ea_d = '0, eb_d = '0, pb_d = '0;
  logic        ea_v = 1'b0, eb_v = 1'b0, pb_v = 1'b0;

  always @(posedge clk) begin
    logic [15:0] old_w, new_w;
    logic        acc_w, acc_r;
    if (rst) begin
      m_busy = 1'b1; m_fill = 0;
      ea_d = '0; ea_v = 1'b0; eb_d = '0; eb_v = 1'b0; pb_v = 1'b0; pb_d = '0;
    end else begin
      acc_w = we && !m_busy;
      acc_r = re && !m_busy;
      old_w = m_mem[r_addr];
      new_w = old_w;
      if (acc_w && w_addr == r_addr) begin
        if (w_be[0]) new_w[7:0]  = w_data[7:0];
        if (w_be[1]) new_w[15:8] = w_data[15:8];
      end
      ea_v = acc_r;
      if (acc_r) ea_d = old_w;
      eb_v = pb_v;
      if (pb_v) eb_d = pb_d;
      pb_v = acc_r;
      if (acc_r) pb_d = new_w;
      if (acc_w) begin
        if (w_be[0]) m_mem[w_addr][7:0]  = w_data[7:0];
        if (w_be[1]) m_mem[w_addr][15:8] = w_data[15:8];
      end
      if (m_busy) begin
        m_mem[m_fill] = '0;
        m_fill++;
        if (m_fill == 8) m_busy = 1'b0;
      end
    end
    #1;
    chk("a_busy",  {15'b0, a_busy},  {15'b0, m_busy});
    chk("b_busy",  {15'b0, b_busy},  {15'b0, m_busy});
    chk("a_valid", {15'b0, a_valid}, {15'b0, ea_v});
    chk("b_valid", {15'b0, b_valid}, {15'b0, eb_v});
    chk("a_data",  a_data, ea_d);
    chk("b_data",  b_data, eb_d);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                     input logic [1:0] be, input logic rd, input logic [2:0] ra);
    @(negedge clk);
    rst = r; we = w; w_addr = wa; w_data = wd; w_be = be; re = rd; r_addr = ra;
    @(posedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0);
  endtask

  initial begin
    int k;
    int vseen;

    // 1. reset, fill for exactly 8 cycles, then all addresses read zero
    repeat (3) cyc(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0);
    #1 chk("reset_busy", {15'b0, a_busy}, 16'h1);
    chk("reset_rdata", b_data, 16'h0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      idle(); k++;
      #1;
      if (!a_busy) break;
    end
    chk("fill_cycles", k[15:0], 16'd8);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, i < 8, 3'(i));
      #1;
      if (i < 8) chk("fill_zero_a", a_data, 16'h0);
      if (i > 0) chk("fill_zero_b_vld", {15'b0, b_valid}, 16'h1);
    end
    idle();

    // 2. single write then read, latency 1 vs 2
    cyc(1'b0, 1'b1, 3'd3, 16'h00A5, 2'b11, 1'b0, 3'd0);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd3);
    #1 chk("wr_rd_a", a_data, 16'h00A5);
    chk("wr_rd_a_vld", {15'b0, a_valid}, 16'h1);
    chk("wr_rd_b_early", {15'b0, b_valid}, 16'h0);
    idle();
    #1 chk("wr_rd_b", b_data, 16'h00A5);
    chk("wr_rd_a_vld_drop", {15'b0, a_valid}, 16'h0);
    idle();

    // 3. byte enables
    cyc(1'b0, 1'b1, 3'd5, 16'h1234, 2'b11, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 3'd5, 16'hABCD, 2'b01, 1'b0, 3'd0);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd5);
    #1 chk("be_merge_a", a_data, 16'h12CD);
    idle();
    #1 chk("be_merge_b", b_data, 16'h12CD);

    // 4. read-during-write on the same address
    cyc(1'b0, 1'b1, 3'd2, 16'h0011, 2'b11, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 3'd2, 16'h0077, 2'b11, 1'b1, 3'd2);
    #1 chk("rdw_old_a", a_data, 16'h0011);
    idle();
    #1 chk("rdw_new_b", b_data, 16'h0077);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd2);
    #1 chk("rdw_after_a", a_data, 16'h0077);
    idle();
    #1 chk("rdw_after_b", b_data, 16'h0077);

    // 6. back-to-back reads after writing addr+0x10
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 3'(i), 16'(i + 16), 2'b11, 1'b0, 3'd0);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, i < 8, 3'(i));
      #1;
      if (i < 8) begin
        chk("burst_a_vld", {15'b0, a_valid}, 16'h1);
        chk("burst_a", a_data, 16'(i + 16));
      end
      if (i > 0) begin
        chk("burst_b_vld", {15'b0, b_valid}, 16'h1);
        chk("burst_b", b_data, 16'(i + 15));
      end
    end
    idle();

    // 5. reset again part way through the fill, with traffic hammering the ports
    repeat (2) cyc(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0);
    repeat (4) cyc(1'b0, 1'b1, 3'd0, 16'h00FF, 2'b11, 1'b1, 3'd0);
    cyc(1'b1, 1'b1, 3'd0, 16'h00FF, 2'b11, 1'b1, 3'd0);
    k = 0; vseen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 3'd0, 16'h00FF, 2'b11, 1'b1, 3'd0); k++;
      #1;
      if (a_valid || b_valid) vseen++;
      if (!a_busy) break;
    end
    chk("refill_cycles", k[15:0], 16'd8);
    chk("refill_no_valid", vseen[15:0], 16'd0);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd0);
    #1 chk("refill_addr0_a", a_data, 16'h0);
    idle();
    #1 chk("refill_addr0_b", b_data, 16'h0);

    // random traffic against the model, with rare resets
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 149) == 0), $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
          16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)));
    end
    repeat (12) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
